// File: rtl/pc_cfr_cpg_bank.sv
// Bank of cancellation pulse generators: peak events are allocated to free generators,
// each plays a shared pulse scaled by a complex factor, and all are summed with saturation.
module pc_cfr_cpg_bank #(
  parameter int DATA_WIDTH     = 16,
  parameter int CPW_ADDR_WIDTH = 8,
  parameter int NUM_CPG        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      peak_valid,
  input  logic [DATA_WIDTH-1:0]     peak_scale_i,
  input  logic [DATA_WIDTH-1:0]     peak_scale_q,
  output logic                      peak_ready,
  output logic [DATA_WIDTH-1:0]     data_i_out,
  output logic [DATA_WIDTH-1:0]     data_q_out,
  input  logic                      ctrl_enable,
  input  logic [CPW_ADDR_WIDTH-1:0] ctrl_cpw_length,
  input  logic                      ctrl_cpw_wr_en,
  input  logic [CPW_ADDR_WIDTH-1:0] ctrl_cpw_wr_addr,
  input  logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_i,
  input  logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_q,
  input  logic                      ctrl_drop_clear,
  output logic [NUM_CPG-1:0]        cpg_busy,
  output logic [15:0]               drop_count
);
  localparam int DEPTH = 2 ** CPW_ADDR_WIDTH;
  localparam int MW    = 2 * DATA_WIDTH;
  localparam int FW    = 2 * DATA_WIDTH + 1;
  localparam int PW    = DATA_WIDTH + 2;
  localparam int SUM_W = DATA_WIDTH + 2 + $clog2(NUM_CPG);
  localparam logic signed [FW-1:0]    RND     = FW'(2 ** (DATA_WIDTH - 2));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_WIDTH - 1)));

  logic [NUM_CPG-1:0]    free_vec;
  logic [NUM_CPG-1:0]    alloc_vec;
  logic signed [PW-1:0]  prod_re [NUM_CPG];
  logic signed [PW-1:0]  prod_im [NUM_CPG];

  assign peak_ready = rst_n && ctrl_enable && (|free_vec);

  // Lowest-index free generator wins; at most one event per cycle.
  always_comb begin
    alloc_vec = '0;
    for (int n = 0; n < NUM_CPG; n++) begin
      if (peak_valid && peak_ready && free_vec[n] && (alloc_vec == '0)) begin
        alloc_vec[n] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CPG; gi++) begin : g_cpg
    logic                          active_q, active_d;
    logic [CPW_ADDR_WIDTH-1:0]     addr_q, addr_d, len_q, len_d;
    logic signed [DATA_WIDTH-1:0]  scale_re_q, scale_re_d, scale_im_q, scale_im_d;
    logic signed [DATA_WIDTH-1:0]  mem_re [DEPTH];
    logic signed [DATA_WIDTH-1:0]  mem_im [DEPTH];
    logic signed [DATA_WIDTH-1:0]  rd_re_q, rd_im_q;
    logic signed [DATA_WIDTH-1:0]  s1_scale_re_q, s1_scale_re_d, s1_scale_im_q, s1_scale_im_d;
    logic                          s1_valid_q, s1_valid_d;
    logic signed [MW-1:0]          p_a, p_b, p_c, p_d;
    logic signed [FW-1:0]          re_full, im_full;
    logic signed [PW-1:0]          prod_re_q, prod_re_d, prod_im_q, prod_im_d;
    logic                          unused_lsbs;

    assign free_vec[gi] = !active_q || (addr_q == len_q);
    assign cpg_busy[gi] = active_q;

    always_comb begin
      active_d   = active_q;
      addr_d     = addr_q;
      len_d      = len_q;
      scale_re_d = scale_re_q;
      scale_im_d = scale_im_q;
      if (alloc_vec[gi]) begin
        active_d   = 1'b1;
        addr_d     = '0;
        len_d      = ctrl_cpw_length;
        scale_re_d = peak_scale_i;
        scale_im_d = peak_scale_q;
      end else if (active_q) begin
        if (addr_q == len_q) active_d = 1'b0;
        else                 addr_d   = addr_q + 1'b1;
      end
    end

    // Private copy of the pulse memory per generator gives each its own read port.
    always_ff @(posedge clk) begin
      if (ctrl_cpw_wr_en) begin
        mem_re[ctrl_cpw_wr_addr] <= ctrl_cpw_wr_data_i;
        mem_im[ctrl_cpw_wr_addr] <= ctrl_cpw_wr_data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_re_q <= '0;
        rd_im_q <= '0;
      end else begin
        rd_re_q <= mem_re[addr_q];
        rd_im_q <= mem_im[addr_q];
      end
    end

    // Scale travels with the sample so back-to-back reuse does not mix events.
    always_comb begin
      s1_valid_d    = active_q;
      s1_scale_re_d = scale_re_q;
      s1_scale_im_d = scale_im_q;
      p_a       = MW'(s1_scale_re_q) * MW'(rd_re_q);
      p_b       = MW'(s1_scale_im_q) * MW'(rd_im_q);
      p_c       = MW'(s1_scale_re_q) * MW'(rd_im_q);
      p_d       = MW'(s1_scale_im_q) * MW'(rd_re_q);
      re_full   = FW'(p_a) - FW'(p_b) + RND;
      im_full   = FW'(p_c) + FW'(p_d) + RND;
      prod_re_d = s1_valid_q ? re_full[FW-1:DATA_WIDTH-1] : '0;
      prod_im_d = s1_valid_q ? im_full[FW-1:DATA_WIDTH-1] : '0;
    end
    assign unused_lsbs = ^{re_full[DATA_WIDTH-2:0], im_full[DATA_WIDTH-2:0]};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        active_q      <= 1'b0;
        addr_q        <= '0;
        len_q         <= '0;
        scale_re_q    <= '0;
        scale_im_q    <= '0;
        s1_valid_q    <= 1'b0;
        s1_scale_re_q <= '0;
        s1_scale_im_q <= '0;
        prod_re_q     <= '0;
        prod_im_q     <= '0;
      end else begin
        active_q      <= active_d;
        addr_q        <= addr_d;
        len_q         <= len_d;
        scale_re_q    <= scale_re_d;
        scale_im_q    <= scale_im_d;
        s1_valid_q    <= s1_valid_d;
        s1_scale_re_q <= s1_scale_re_d;
        s1_scale_im_q <= s1_scale_im_d;
        prod_re_q     <= prod_re_d;
        prod_im_q     <= prod_im_d;
      end
    end

    assign prod_re[gi] = prod_re_q;
    assign prod_im[gi] = prod_im_q;
  end

  logic signed [SUM_W-1:0]      sum_re, sum_im;
  logic signed [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [15:0]                  drop_count_q, drop_count_d;

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int n = 0; n < NUM_CPG; n++) begin
      sum_re = sum_re + SUM_W'(prod_re[n]);
      sum_im = sum_im + SUM_W'(prod_im[n]);
    end
    if (sum_re > SAT_MAX)      out_re_d = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum_re < SAT_MIN) out_re_d = SAT_MIN[DATA_WIDTH-1:0];
    else                       out_re_d = sum_re[DATA_WIDTH-1:0];
    if (sum_im > SAT_MAX)      out_im_d = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum_im < SAT_MIN) out_im_d = SAT_MIN[DATA_WIDTH-1:0];
    else                       out_im_d = sum_im[DATA_WIDTH-1:0];
  end

  // Refused events only count as drops while the bank is enabled.
  always_comb begin
    drop_count_d = drop_count_q;
    if (ctrl_drop_clear) begin
      drop_count_d = '0;
    end else if (peak_valid && ctrl_enable && !peak_ready && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_re_q     <= '0;
      out_im_q     <= '0;
      drop_count_q <= '0;
    end else begin
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign data_i_out = out_re_q;
  assign data_q_out = out_im_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_pc_cfr_cpg_bank.sv
// Bench for pc_cfr_cpg_bank: directed scenarios plus random events, checked every cycle
// against an event-list model of the generator bank.
module tb_pc_cfr_cpg_bank;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 4;

  logic          clk;
  logic          rst_n;
  logic          peak_valid;
  logic [DW-1:0] peak_scale_i, peak_scale_q;
  logic          peak_ready;
  logic [DW-1:0] data_i_out, data_q_out;
  logic          ctrl_enable;
  logic [AW-1:0] ctrl_cpw_length;
  logic          ctrl_cpw_wr_en;
  logic [AW-1:0] ctrl_cpw_wr_addr;
  logic [DW-1:0] ctrl_cpw_wr_data_i, ctrl_cpw_wr_data_q;
  logic          ctrl_drop_clear;
  logic [N-1:0]  cpg_busy;
  logic [15:0]   drop_count;

  pc_cfr_cpg_bank #(.DATA_WIDTH(DW), .CPW_ADDR_WIDTH(AW), .NUM_CPG(N)) dut (
    .clk(clk), .rst_n(rst_n), .peak_valid(peak_valid),
    .peak_scale_i(peak_scale_i), .peak_scale_q(peak_scale_q), .peak_ready(peak_ready),
    .data_i_out(data_i_out), .data_q_out(data_q_out), .ctrl_enable(ctrl_enable),
    .ctrl_cpw_length(ctrl_cpw_length), .ctrl_cpw_wr_en(ctrl_cpw_wr_en),
    .ctrl_cpw_wr_addr(ctrl_cpw_wr_addr), .ctrl_cpw_wr_data_i(ctrl_cpw_wr_data_i),
    .ctrl_cpw_wr_data_q(ctrl_cpw_wr_data_q), .ctrl_drop_clear(ctrl_drop_clear),
    .cpg_busy(cpg_busy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     a;
    int     gen;
    int     len;
    longint si;
    longint sq;
  } ev_t;

  ev_t    evq[$];
  longint mem_re_m[256];
  longint mem_im_m[256];
  int     drop_m;
  int     cur;
  int     checks;
  int     errors;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, cur);
    end
  endtask

  // Generator n holds an event that is not on its final sample in the cycle after edge c.
  function automatic bit occupied(int n, int c);
    foreach (evq[j]) if (evq[j].gen == n && evq[j].a <= c && c < evq[j].a + evq[j].len) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_after(int n, int c);
    foreach (evq[j]) if (evq[j].gen == n && evq[j].a <= c && c <= evq[j].a + evq[j].len) return 1'b1;
    return 1'b0;
  endfunction

  // Sample k of an event accepted at edge a is on the output after edge a+3+k.
  function automatic longint model_out(bit imag, int e);
    longint s, v;
    int k;
    s = 0;
    foreach (evq[j]) begin
      k = e - evq[j].a - 3;
      if (k >= 0 && k <= evq[j].len) begin
        if (imag) v = evq[j].si * mem_im_m[k] + evq[j].sq * mem_re_m[k];
        else      v = evq[j].si * mem_re_m[k] - evq[j].sq * mem_im_m[k];
        s += (v + 16384) >>> 15;
      end
    end
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // One clock: check ready mid-cycle, apply the edge to the model, check registered outputs.
  task automatic tick();
    bit           rdy_m;
    int           g;
    ev_t          ev;
    logic [N-1:0] busy_m;
    #1;
    g = -1;
    if (rst_n && ctrl_enable)
      for (int n = N - 1; n >= 0; n--) if (!occupied(n, cur)) g = n;
    rdy_m = (g >= 0);
    check_eq("peak_ready", longint'(peak_ready), longint'(rdy_m));
    @(posedge clk);
    cur++;
    if (ctrl_cpw_wr_en) begin
      mem_re_m[ctrl_cpw_wr_addr] = longint'($signed(ctrl_cpw_wr_data_i));
      mem_im_m[ctrl_cpw_wr_addr] = longint'($signed(ctrl_cpw_wr_data_q));
    end
    if (!rst_n) begin
      evq.delete();
      drop_m = 0;
    end else begin
      if (ctrl_drop_clear) drop_m = 0;
      else if (peak_valid && ctrl_enable && !rdy_m && drop_m < 65535) drop_m++;
      if (peak_valid && rdy_m) begin
        ev.a   = cur;
        ev.gen = g;
        ev.len = int'(ctrl_cpw_length);
        ev.si  = longint'($signed(peak_scale_i));
        ev.sq  = longint'($signed(peak_scale_q));
        evq.push_back(ev);
      end
    end
    #1;
    for (int n = 0; n < N; n++) busy_m[n] = busy_after(n, cur);
    check_eq("data_i_out", longint'($signed(data_i_out)), model_out(1'b0, cur));
    check_eq("data_q_out", longint'($signed(data_q_out)), model_out(1'b1, cur));
    check_eq("cpg_busy", longint'(cpg_busy), longint'(busy_m));
    check_eq("drop_count", longint'(drop_count), longint'(drop_m));
    for (int j = evq.size() - 1; j >= 0; j--)
      if (cur > evq[j].a + evq[j].len + 3) evq.delete(j);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mem(input int addr, input int re, input int im);
    ctrl_cpw_wr_en     = 1'b1;
    ctrl_cpw_wr_addr   = AW'(addr);
    ctrl_cpw_wr_data_i = DW'(re);
    ctrl_cpw_wr_data_q = DW'(im);
    tick();
    ctrl_cpw_wr_en     = 1'b0;
  endtask

  task automatic fire(input int si, input int sq);
    peak_valid   = 1'b1;
    peak_scale_i = DW'(si);
    peak_scale_q = DW'(sq);
    tick();
    peak_valid   = 1'b0;
  endtask

  initial begin
    int t;
    checks = 0;
    errors = 0;
    cur    = 0;
    drop_m = 0;
    foreach (mem_re_m[i]) begin
      mem_re_m[i] = 0;
      mem_im_m[i] = 0;
    end
    rst_n = 1'b0; peak_valid = 1'b0; peak_scale_i = '0; peak_scale_q = '0;
    ctrl_enable = 1'b1; ctrl_cpw_length = 8'd7; ctrl_cpw_wr_en = 1'b0;
    ctrl_cpw_wr_addr = '0; ctrl_cpw_wr_data_i = '0; ctrl_cpw_wr_data_q = '0;
    ctrl_drop_clear = 1'b0;
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Ramp pulse i[k] = 16k, half scale.
    for (int k = 0; k < 256; k++) write_mem(k, k * 16, 0);
    ctrl_cpw_length = 8'd7;
    fire(16384, 0);
    idle(4);
    check_eq("ramp_sample1", longint'($signed(data_i_out)), 8);
    idle(15);

    // Four long events fill the bank; the fifth is dropped.
    ctrl_cpw_length = 8'd15;
    peak_valid = 1'b1; peak_scale_i = DW'(8000); peak_scale_q = DW'(-3000);
    idle(5);
    peak_valid = 1'b0;
    check_eq("drop_after_5", longint'(drop_count), 1);
    idle(10);

    // Reset mid-pulse, then the same pulse replays.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_eq("rst_busy", longint'(cpg_busy), 0);
    check_eq("rst_drop", longint'(drop_count), 0);
    ctrl_cpw_length = 8'd7;
    fire(16384, 0);
    idle(5);
    check_eq("replay_sample2", longint'($signed(data_i_out)), 16);
    idle(12);

    // Purely imaginary scale against a constant real pulse.
    for (int k = 0; k < 4; k++) write_mem(k, 16384, 0);
    ctrl_cpw_length = 8'd3;
    fire(0, 32767);
    idle(3);
    check_eq("imag_q", longint'($signed(data_q_out)), 16384);
    check_eq("imag_i", longint'($signed(data_i_out)), 0);
    idle(8);

    // Length 3 events every 4 cycles reuse generator 0 with no gap.
    for (int r = 0; r < 5; r++) begin
      fire(12000 - r * 5000, r * 3000);
      idle(3);
    end
    idle(8);

    // Overlapping full-scale events saturate both ways.
    for (int k = 0; k < 16; k++) write_mem(k, 32767, 0);
    ctrl_cpw_length = 8'd15;
    for (int r = 0; r < 4; r++) fire(32767, 0);
    idle(3);
    check_eq("sat_pos", longint'($signed(data_i_out)), 32767);
    idle(18);
    for (int r = 0; r < 4; r++) fire(-32768, 0);
    idle(3);
    check_eq("sat_neg", longint'($signed(data_i_out)), -32768);
    idle(18);

    // Random traffic over a random pulse.
    for (int k = 0; k < 32; k++) begin
      t = int'($urandom_range(48000)) - 24000;
      write_mem(k, t, int'($urandom_range(48000)) - 24000);
    end
    for (int i = 0; i < 800; i++) begin
      peak_valid      = ($urandom_range(2) == 0);
      ctrl_enable     = ($urandom_range(7) != 0);
      ctrl_cpw_length = AW'($urandom_range(19));
      ctrl_drop_clear = ($urandom_range(49) == 0);
      peak_scale_i    = DW'(int'($urandom_range(48000)) - 24000);
      peak_scale_q    = DW'(int'($urandom_range(48000)) - 24000);
      tick();
    end
    peak_valid = 1'b0;
    ctrl_drop_clear = 1'b0;
    ctrl_enable = 1'b1;
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
